// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared types and line constants for the
// serial frame receiver (FSM encoding, bit levels, DIR codes).
package serial_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rxState_t;

  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam logic IDLE_LEVEL    = 1'b1;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: small word FIFO with registered head/valid.
// Ports: clk, rstN, push/pushData in, popReady in,
// head/headValid out, overrun pulse out.
module rx_word_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popReady,
  output logic [WIDTH-1:0] head,
  output logic             headValid,
  output logic             overrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtrInc;
  logic [CW-1:0]    count;
  logic [CW-1:0]    countNext;
  logic             full;
  logic             doPop;
  logic             doPush;

  always_comb begin
    full      = (count == CW'(DEPTH));
    doPop     = headValid & popReady;
    // a pop on the same edge frees the slot
    doPush    = push & (~full | doPop);
    countNext = count + CW'(doPush) - CW'(doPop);
    rdPtrInc  = rdPtr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      head      <= '0;
      headValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun   <= push & ~doPush;
      count     <= countNext;
      headValid <= (countNext != '0);
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtrInc;
      // head tracks the entry at the read pointer
      // after this edge; bypass when it is the
      // word being written now
      if (countNext == '0)
        head <= '0;
      else if (doPop)
        head <= (count > CW'(1)) ? mem[rdPtrInc]
                                 : pushData;
      else if (count == '0)
        head <= pushData;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/parity/stop deserialiser feeding
// a word FIFO. Ports: CLK, RST_N, ENB, DIR, S_IN, Q, Q_VALID,
// Q_READY, PAR_ERR, FRM_ERR, OVERRUN, BUSY.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             PAR_ERR,
  output logic             FRM_ERR,
  output logic             OVERRUN,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rxState_t         state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic             dirL;
  logic             parBad;
  logic             parErrQ;
  logic             frmErrQ;
  logic             busyQ;
  logic             push;

  // push goes straight to the FIFO on the stop edge
  assign push = ENB && (state == ST_STOP)
             && (S_IN == STOP_BIT) && !parBad;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sh      <= '0;
      dirL    <= DIR_LSB_FIRST;
      parBad  <= 1'b0;
      parErrQ <= 1'b0;
      frmErrQ <= 1'b0;
      busyQ   <= 1'b0;
    end else begin
      parErrQ <= 1'b0;
      frmErrQ <= 1'b0;
      if (ENB) begin
        unique case (state)
          ST_IDLE: begin
            if (S_IN == START_BIT) begin
              state <= ST_DATA;
              dirL  <= DIR;
              cnt   <= '0;
              busyQ <= 1'b1;
            end
          end
          ST_DATA: begin
            if (dirL == DIR_MSB_FIRST)
              sh <= {sh[WIDTH-2:0], S_IN};
            else
              sh <= {S_IN, sh[WIDTH-1:1]};
            if (cnt == LAST) begin
              state <= ST_PARITY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_PARITY: begin
            parBad <= (^sh) ^ S_IN;
            state  <= ST_STOP;
          end
          ST_STOP: begin
            if (S_IN == STOP_BIT) begin
              parErrQ <= parBad;
              state   <= ST_IDLE;
              busyQ   <= 1'b0;
            end else begin
              // framing error masks a parity error
              frmErrQ <= 1'b1;
              state   <= ST_BREAK;
            end
          end
          ST_BREAK: begin
            if (S_IN == IDLE_LEVEL) begin
              state <= ST_IDLE;
              busyQ <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busyQ <= 1'b0;
          end
        endcase
      end
    end
  end

  rx_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk       (CLK),
    .rstN      (RST_N),
    .push      (push),
    .pushData  (sh),
    .popReady  (Q_READY),
    .head      (Q),
    .headValid (Q_VALID),
    .overrun   (OVERRUN)
  );

  assign PAR_ERR = parErrQ;
  assign FRM_ERR = frmErrQ;
  assign BUSY    = busyQ;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: vector table, directed corner sequences and
// randomized frames checked against a word-queue reference model.
module tb_serial_frame_rx;

  localparam int W = 4;
  localparam int D = 2;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         ENB;
  logic         DIR;
  logic         S_IN;
  logic         Q_READY;
  logic [W-1:0] Q;
  logic         Q_VALID;
  logic         PAR_ERR;
  logic         FRM_ERR;
  logic         OVERRUN;
  logic         BUSY;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  logic expPar = 1'b0;
  logic expFrm = 1'b0;
  logic expOvr = 1'b0;

  typedef struct {
    logic       dir;
    logic [6:0] bits;
    logic       expValid;
    logic [3:0] expQ;
    logic       expPar;
    logic       expFrm;
  } vec_t;

  vec_t vecs[7];

  serial_frame_rx #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .ENB     (ENB),
    .DIR     (DIR),
    .S_IN    (S_IN),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_READY (Q_READY),
    .PAR_ERR (PAR_ERR),
    .FRM_ERR (FRM_ERR),
    .OVERRUN (OVERRUN),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drv(input logic e, input logic s,
                     input logic d, input logic r);
    ENB = e; S_IN = s; DIR = d; Q_READY = r;
    @(negedge CLK);
  endtask

  // time-ordered line bits: index 0 goes out first
  function automatic logic [W+2:0] frameBits(
    input logic dir, input logic [W-1:0] data,
    input logic badPar, input logic badStop);
    logic [W+2:0] fb;
    fb[0] = 1'b0;
    for (int i = 0; i < W; i++)
      fb[1+i] = dir ? data[W-1-i] : data[i];
    fb[W+1] = (^data) ^ badPar;
    fb[W+2] = ~badStop;
    return fb;
  endfunction

  task automatic sendRaw(input logic dir,
                         input logic [W-1:0] data,
                         input logic rdyOnStop);
    logic [W+2:0] fb;
    fb = frameBits(dir, data, 1'b0, 1'b0);
    for (int i = 0; i < W + 3; i++)
      drv(1'b1, fb[i], dir,
          (i == W + 2) ? rdyOnStop : 1'b0);
  endtask

  // one cycle under the reference model: check what the
  // previous edge should have produced, then drive
  task automatic step(input logic e, input logic s,
                      input logic d, input logic r,
                      input int ev, input logic [W-1:0] w);
    logic [W-1:0] tmp;
    logic pop;
    chk("rnd_parErr", 32'(PAR_ERR), 32'(expPar));
    chk("rnd_frmErr", 32'(FRM_ERR), 32'(expFrm));
    chk("rnd_overrun", 32'(OVERRUN), 32'(expOvr));
    chk("rnd_qValid", 32'(Q_VALID), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("rnd_q", 32'(Q), 32'(mq[0]));
    ENB = e; S_IN = s; DIR = d; Q_READY = r;
    pop = (mq.size() != 0) && r;
    expPar = 1'b0; expFrm = 1'b0; expOvr = 1'b0;
    if (pop) tmp = mq.pop_front();
    if (e) begin
      case (ev)
        1: if (mq.size() < D) mq.push_back(w);
           else expOvr = 1'b1;
        2: expPar = 1'b1;
        3: expFrm = 1'b1;
        default: ;
      endcase
    end
    @(negedge CLK);
  endtask

  function automatic logic rndRdy();
    return ($urandom_range(0, 2) == 0);
  endfunction

  task automatic sendRand(input logic dir,
                          input logic [W-1:0] data,
                          input logic badPar,
                          input logic badStop);
    logic [W+2:0] fb;
    int ev;
    fb = frameBits(dir, data, badPar, badStop);
    ev = badStop ? 3 : (badPar ? 2 : 1);
    for (int i = 0; i < W + 3; i++) begin
      if ($urandom_range(0, 3) == 0)
        for (int g = 0; g < $urandom_range(1, 2); g++)
          step(1'b0, 1'($urandom), 1'($urandom),
               rndRdy(), 0, '0);
      step(1'b1, fb[i], (i == 0) ? dir : 1'($urandom),
           rndRdy(), (i == W + 2) ? ev : 0, data);
    end
    if (badStop) begin
      for (int g = 0; g < $urandom_range(0, 2); g++)
        step(1'b1, 1'b0, 1'($urandom), rndRdy(), 0, '0);
      step(1'b1, 1'b1, 1'($urandom), rndRdy(), 0, '0);
    end
    for (int g = 0; g < $urandom_range(0, 2); g++)
      step(1'b1, 1'b1, 1'($urandom), rndRdy(), 0, '0);
  endtask

  initial begin
    logic [W+2:0] fb;

    vecs[0] = '{1'b0, 7'b0110111, 1'b1, 4'hB, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 7'b0101111, 1'b1, 4'hB, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 7'b0110101, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 7'b0000000, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 7'b0101001, 1'b1, 4'h5, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 7'b0101001, 1'b1, 4'hA, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 7'b0111101, 1'b1, 4'hF, 1'b0, 1'b0};

    RST_N = 1'b0; ENB = 1'b0; S_IN = 1'b1;
    DIR = 1'b0; Q_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_qValid", 32'(Q_VALID), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_errs", 32'({PAR_ERR, FRM_ERR, OVERRUN}), 32'h0);
    RST_N = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 1'b0);

    // vector table
    foreach (vecs[k]) begin
      for (int i = 0; i < 7; i++)
        drv(1'b1, vecs[k].bits[6-i], vecs[k].dir, 1'b0);
      chk($sformatf("vec%0d_qValid", k),
          32'(Q_VALID), 32'(vecs[k].expValid));
      if (vecs[k].expValid)
        chk($sformatf("vec%0d_q", k),
            32'(Q), 32'(vecs[k].expQ));
      chk($sformatf("vec%0d_parErr", k),
          32'(PAR_ERR), 32'(vecs[k].expPar));
      chk($sformatf("vec%0d_frmErr", k),
          32'(FRM_ERR), 32'(vecs[k].expFrm));
      chk($sformatf("vec%0d_overrun", k), 32'(OVERRUN), 32'h0);
      drv(1'b1, 1'b1, 1'b0, 1'b1);
      chk($sformatf("vec%0d_drop", k), 32'(Q_VALID), 32'h0);
      chk($sformatf("vec%0d_pulseEnd", k),
          32'({PAR_ERR, FRM_ERR}), 32'h0);
      chk($sformatf("vec%0d_idle", k), 32'(BUSY), 32'h0);
    end

    // MSB first with ENB gaps; DIR changes after start
    fb = frameBits(1'b1, 4'hB, 1'b0, 1'b0);
    for (int i = 0; i < W + 3; i++) begin
      drv(1'b1, fb[i], (i == 0) ? 1'b1 : 1'b0, 1'b0);
      if (i < W + 2) begin
        chk("gap_busyA", 32'(BUSY), 32'h1);
        drv(1'b0, ~fb[i], 1'b0, 1'b0);
        chk("gap_busyB", 32'(BUSY), 32'h1);
      end
    end
    chk("gap_qValid", 32'(Q_VALID), 32'h1);
    chk("gap_q", 32'(Q), 32'hB);
    chk("gap_busyEnd", 32'(BUSY), 32'h0);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    chk("gap_drop", 32'(Q_VALID), 32'h0);

    // framing error then break
    for (int i = 0; i < 7; i++) drv(1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_frmErr", 32'(FRM_ERR), 32'h1);
    chk("brk_parErr", 32'(PAR_ERR), 32'h0);
    chk("brk_busy0", 32'(BUSY), 32'h1);
    drv(1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_frmOnce", 32'(FRM_ERR), 32'h0);
    chk("brk_busy1", 32'(BUSY), 32'h1);
    drv(1'b1, 1'b0, 1'b0, 1'b0);
    chk("brk_busy2", 32'(BUSY), 32'h1);
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    chk("brk_exit", 32'(BUSY), 32'h0);
    sendRaw(1'b0, 4'h5, 1'b0);
    chk("brk_nextValid", 32'(Q_VALID), 32'h1);
    chk("brk_nextQ", 32'(Q), 32'h5);
    chk("brk_nextErr", 32'({PAR_ERR, FRM_ERR}), 32'h0);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    chk("brk_drop", 32'(Q_VALID), 32'h0);

    // overrun with full FIFO
    sendRaw(1'b0, 4'h1, 1'b0);
    sendRaw(1'b0, 4'h2, 1'b0);
    chk("ovr_none2", 32'(OVERRUN), 32'h0);
    sendRaw(1'b0, 4'h3, 1'b0);
    chk("ovr_pulse", 32'(OVERRUN), 32'h1);
    chk("ovr_head1", 32'(Q), 32'h1);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovr_pulseEnd", 32'(OVERRUN), 32'h0);
    chk("ovr_head2", 32'(Q), 32'h2);
    chk("ovr_valid2", 32'(Q_VALID), 32'h1);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovr_empty", 32'(Q_VALID), 32'h0);

    // full, but a pop lands on the stop edge
    sendRaw(1'b0, 4'h1, 1'b0);
    sendRaw(1'b0, 4'h2, 1'b0);
    sendRaw(1'b0, 4'h3, 1'b1);
    chk("ovrPop_none", 32'(OVERRUN), 32'h0);
    chk("ovrPop_head2", 32'(Q), 32'h2);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovrPop_head3", 32'(Q), 32'h3);
    chk("ovrPop_valid3", 32'(Q_VALID), 32'h1);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovrPop_empty", 32'(Q_VALID), 32'h0);

    // asynchronous reset mid-frame with a word queued
    sendRaw(1'b0, 4'h6, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ar_preBusy", 32'(BUSY), 32'h1);
    #2 RST_N = 1'b0;
    S_IN = 1'b1;
    #1;
    chk("ar_qValid", 32'(Q_VALID), 32'h0);
    chk("ar_busy", 32'(BUSY), 32'h0);
    chk("ar_q", 32'(Q), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ar_stillEmpty", 32'(Q_VALID), 32'h0);
    sendRaw(1'b0, 4'hA, 1'b0);
    chk("ar_freshValid", 32'(Q_VALID), 32'h1);
    chk("ar_freshQ", 32'(Q), 32'hA);
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b0, 1'b0);

    // randomized frames against the queue model
    mq.delete();
    expPar = 1'b0; expFrm = 1'b0; expOvr = 1'b0;
    for (int f = 0; f < 160; f++)
      sendRand(1'($urandom), W'($urandom),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0));
    for (int g = 0; g < D + 3; g++)
      step(1'b1, 1'b1, 1'b0, 1'b1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
